dram_read_return: RTL and testbench

//  Read-data return path, DRAM side to host side. Collects DQ read bursts from every (rank, channel) lane

---
 rtl/dram_read_return.sv | 209 ++++++++++++++++++++
 tb/tb_dram_read_return.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_read_return.sv
// dram_read_return: collects DRAM read beats from every (rank, channel) lane into
// per-lane FIFOs and round-robin arbitrates them onto one valid/ready host port.
// Optional feature macro: RD_PARITY_EN (per-beat even parity check and host_par_err).
module dram_read_return #(
  parameter int DQ_WIDTH     = 8,
  parameter int NUM_RANKS    = 2,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 8,
  localparam int NUM_LANES   = NUM_RANKS * NUM_CHANNELS,
  localparam int RW          = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1,
  localparam int CW          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RANKS-1:0]          cfg_rank_en,
  input  logic [NUM_CHANNELS-1:0]       cfg_channel_en,
  input  logic [NUM_LANES*DQ_WIDTH-1:0] dram_dq_in,
  input  logic [NUM_LANES-1:0]          dram_rd_valid,
  input  logic                          flush_req,
  output logic [DQ_WIDTH-1:0]           host_dq_out,
  output logic [RW-1:0]                 host_rank,
  output logic [CW-1:0]                 host_channel,
  output logic                          host_rd_valid,
  input  logic                          host_rd_ready,
`ifdef RD_PARITY_EN
  input  logic [NUM_LANES-1:0]          dram_par_in,
  output logic                          host_par_err,
`endif
  output logic                          flush_done,
  output logic                          error_status,
  output logic [NUM_LANES-1:0]          error_lane
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t                state_reg, state_next;
  logic                  flush_done_reg, flush_done_next;
  logic [NUM_LANES-1:0]  lane_en, nonempty, full, push_acc, pop, push_err;
  logic [DQ_WIDTH-1:0]   head_data [NUM_LANES];
  logic [LW-1:0]         last_grant_reg, grant_idx, cand;
  logic                  grant_valid, load_out, drain_done;
  int                    idx;

  logic [DQ_WIDTH-1:0]   host_dq_reg;
  logic [RW-1:0]         host_rank_reg;
  logic [CW-1:0]         host_channel_reg;
  logic                  host_valid_reg;
  logic [NUM_LANES-1:0]  error_lane_reg;
  logic                  error_status_reg;
`ifdef RD_PARITY_EN
  logic [NUM_LANES-1:0]  head_perr;
  logic                  host_par_err_reg;
`endif

  // Output register may take a new beat when empty or when its beat is taken this edge;
  // a flush overrides any transfer.
  assign load_out = (~host_valid_reg | host_rd_ready) & ~flush_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [DQ_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
      logic [PW:0]         count_reg;
      logic [DQ_WIDTH-1:0] beat;
      logic                par_bad;

      assign beat         = dram_dq_in[gi*DQ_WIDTH +: DQ_WIDTH];
      assign lane_en[gi]  = cfg_rank_en[gi / NUM_CHANNELS] & cfg_channel_en[gi % NUM_CHANNELS];
      assign nonempty[gi] = (count_reg != '0);
      assign full[gi]     = (count_reg == (PW+1)'(FIFO_DEPTH));
      assign pop[gi]      = load_out & grant_valid & (grant_idx == LW'(gi));
      // A full FIFO still accepts when its head leaves on the same edge.
      assign push_acc[gi] = dram_rd_valid[gi] & ~flush_req & lane_en[gi] & (~full[gi] | pop[gi]);
      assign head_data[gi] = mem[rd_ptr_reg];
`ifdef RD_PARITY_EN
      logic perr_mem [FIFO_DEPTH];
      assign par_bad       = ^{beat, dram_par_in[gi]};
      assign head_perr[gi] = perr_mem[rd_ptr_reg];
      // Keep the parity verdict alongside each stored beat.
      always_ff @(posedge clk) begin
        if (push_acc[gi]) perr_mem[wr_ptr_reg] <= par_bad;
      end
`else
      assign par_bad = 1'b0;
`endif
      // Disabled-lane beats and overflow drops are errors; flush-cycle drops are not.
      assign push_err[gi] = (dram_rd_valid[gi] & ~flush_req &
                             (~lane_en[gi] | (full[gi] & ~pop[gi]))) |
                            (push_acc[gi] & par_bad);

      // Beat storage, written at the tail pointer.
      always_ff @(posedge clk) begin
        if (push_acc[gi]) mem[wr_ptr_reg] <= beat;
      end

      // Pointers and occupancy; reset and flush both empty the FIFO.
      always_ff @(posedge clk) begin
        if (!rst_n || flush_req) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push_acc[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])      rd_ptr_reg <= rd_ptr_reg + 1'b1;
          count_reg <= count_reg + (PW+1)'(push_acc[gi]) - (PW+1)'(pop[gi]);
        end
      end
    end
  endgenerate

  // Round-robin pick: first non-empty lane after the previous winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int i = 1; i <= NUM_LANES; i++) begin
      idx  = (int'(last_grant_reg) + i) % NUM_LANES;
      cand = LW'(idx);
      if (!grant_valid && nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Host output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_req) begin
      host_valid_reg   <= 1'b0;
      host_dq_reg      <= '0;
      host_rank_reg    <= '0;
      host_channel_reg <= '0;
`ifdef RD_PARITY_EN
      host_par_err_reg <= 1'b0;
`endif
      if (!rst_n) last_grant_reg <= LW'(NUM_LANES - 1);
    end else if (load_out) begin
      host_valid_reg <= grant_valid;
      if (grant_valid) begin
        host_dq_reg      <= head_data[grant_idx];
        host_rank_reg    <= RW'(int'(grant_idx) / NUM_CHANNELS);
        host_channel_reg <= CW'(int'(grant_idx) % NUM_CHANNELS);
`ifdef RD_PARITY_EN
        host_par_err_reg <= head_perr[grant_idx];
`endif
        last_grant_reg   <= grant_idx;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      error_lane_reg   <= '0;
      error_status_reg <= 1'b0;
    end else begin
      error_lane_reg   <= error_lane_reg | push_err;
      error_status_reg <= error_status_reg | (|push_err);
    end
  end

  // Everything drained: no buffered beats, none arriving, output beat gone this edge.
  assign drain_done = ~(|nonempty) & ~(|push_acc) & (~host_valid_reg | host_rd_ready);

  // FSM state register plus registered flush_done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      flush_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      flush_done_reg <= flush_done_next;
    end
  end

  // Next-state logic; flush_done fires only on entry into FLUSH.
  always_comb begin
    state_next      = state_reg;
    flush_done_next = 1'b0;
    if (flush_req) begin
      state_next      = FLUSH;
      flush_done_next = (state_reg != FLUSH);
    end else begin
      case (state_reg)
        IDLE:    if (|push_acc) state_next = ACTIVE;
        ACTIVE:  if (drain_done) state_next = IDLE;
        FLUSH:   state_next = (|push_acc) ? ACTIVE : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign host_dq_out   = host_dq_reg;
  assign host_rank     = host_rank_reg;
  assign host_channel  = host_channel_reg;
  assign host_rd_valid = host_valid_reg;
  assign flush_done    = flush_done_reg;
  assign error_status  = error_status_reg;
  assign error_lane    = error_lane_reg;
`ifdef RD_PARITY_EN
  assign host_par_err  = host_par_err_reg;
`endif

endmodule

// File: tb/tb_dram_read_return.sv
// Scoreboard bench for dram_read_return (default build, 2 ranks x 2 channels, depth 8).
module tb_dram_read_return;
  localparam int DQ = 8, NR = 2, NC = 2, NL = 4, FD = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] cfg_rank_en;
  logic [NC-1:0] cfg_channel_en;
  logic [NL*DQ-1:0] dram_dq_in;
  logic [NL-1:0] dram_rd_valid;
  logic          flush_req;
  logic [DQ-1:0] host_dq_out;
  logic          host_rank;
  logic          host_channel;
  logic          host_rd_valid;
  logic          host_rd_ready;
  logic          flush_done;
  logic          error_status;
  logic [NL-1:0] error_lane;

  typedef struct packed { logic [7:0] dq; logic r; logic c; } beat_t;
  beat_t exp_q[$];
  beat_t mon_e;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dram_read_return #(.DQ_WIDTH(DQ), .NUM_RANKS(NR), .NUM_CHANNELS(NC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_rank_en(cfg_rank_en), .cfg_channel_en(cfg_channel_en),
    .dram_dq_in(dram_dq_in), .dram_rd_valid(dram_rd_valid), .flush_req(flush_req),
    .host_dq_out(host_dq_out), .host_rank(host_rank), .host_channel(host_channel),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready), .flush_done(flush_done),
    .error_status(error_status), .error_lane(error_lane)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input int lane, input logic [7:0] d);
    beat_t b;
    b.dq = d;
    b.r  = 1'(lane / NC);
    b.c  = 1'(lane % NC);
    exp_q.push_back(b);
  endtask

  // Drive one cycle of lane beats, then idle the lanes.
  task automatic drive(input logic [NL-1:0] v, input logic [31:0] dq);
    dram_rd_valid = v;
    dram_dq_in    = dq;
    step();
    dram_rd_valid = '0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: every accepted host beat is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && host_rd_valid && host_rd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got dq=%0h rank=%0d ch=%0d required none",
                 host_dq_out, host_rank, host_channel);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_dq", host_dq_out, mon_e.dq);
        check("beat_rank", host_rank, mon_e.r);
        check("beat_channel", host_channel, mon_e.c);
      end
    end
  end

  initial begin
    rst_n = 1'b0; cfg_rank_en = 2'b11; cfg_channel_en = 2'b11;
    dram_dq_in = '0; dram_rd_valid = '0; flush_req = 1'b0; host_rd_ready = 1'b0;
    step(); step();
    check("rst_valid", host_rd_valid, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_err_status", error_status, 0);
    check("rst_err_lane", error_lane, 0);
    check("rst_dq", host_dq_out, 0);
    rst_n = 1'b1;
    step();

    // Four lanes at once from reset: round-robin starts at lane 0, back-to-back output.
    host_rd_ready = 1'b1;
    for (int l = 0; l < NL; l++) expect_beat(l, 8'h10 + 8'(l));
    drive(4'b1111, 32'h13121110);
    check("rr_latency_e0", host_rd_valid, 0);
    for (int k = 0; k < NL; k++) begin
      step();
      check("rr_back_to_back", host_rd_valid, 1);
    end
    step();
    check("rr_done_valid", host_rd_valid, 0);

    // Single beat latency: valid appears after the edge following the push.
    expect_beat(0, 8'hA5);
    drive(4'b0001, 32'h000000A5);
    check("lat_e0_valid", host_rd_valid, 0);
    step();
    check("lat_e1_valid", host_rd_valid, 1);
    step();
    check("lat_consumed", host_rd_valid, 0);
    check("lat_no_error", error_status, 0);

    // Overflow: output register held by a lane-0 beat, then 9 beats on lane 2.
    host_rd_ready = 1'b0;
    expect_beat(0, 8'h0F);
    drive(4'b0001, 32'h0000000F);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_beat(2, 8'h20 + 8'(i));
      drive(4'b0100, {8'h00, 8'h20 + 8'(i), 16'h0000});
      if (i == 7) check("ovf_before_9th", error_lane, 0);
    end
    check("ovf_err_lane", error_lane, 4'b0100);
    check("ovf_err_status", error_status, 1);
    check("ovf_held_dq", host_dq_out, 8'h0F);
    host_rd_ready = 1'b1;
    drain(40);

    // Disabled rank 1: lane 3 beat dropped with error.
    cfg_rank_en = 2'b01;
    drive(4'b1000, 32'h77000000);
    check("dis_valid_e0", host_rd_valid, 0);
    step();
    check("dis_valid_e1", host_rd_valid, 0);
    check("dis_err_lane3", error_lane[3], 1);
    check("dis_err_lane", error_lane, 4'b1100);
    cfg_rank_en = 2'b11;

    // Flush with four beats buffered; a push in the flush cycle is silently dropped.
    host_rd_ready = 1'b0;
    drive(4'b1111, 32'h33323130);
    step();
    check("flush_pre_valid", host_rd_valid, 1);
    flush_req = 1'b1;
    dram_rd_valid = 4'b0100;
    dram_dq_in = 32'h00440000;
    step();
    flush_req = 1'b0;
    dram_rd_valid = '0;
    check("flush_valid", host_rd_valid, 0);
    check("flush_done_pulse", flush_done, 1);
    check("flush_no_new_err", error_lane, 4'b1100);
    step();
    check("flush_done_clear", flush_done, 0);
    host_rd_ready = 1'b1;
    step();
    check("flush_nothing_left", host_rd_valid, 0);
    expect_beat(1, 8'h5A);
    drive(4'b0010, 32'h00005A00);
    step();
    check("post_flush_valid", host_rd_valid, 1);
    step();

    // Flush held high for three cycles: one flush_done pulse.
    flush_req = 1'b1;
    step();
    check("hold_flush_pulse", flush_done, 1);
    step();
    check("hold_flush_c2", flush_done, 0);
    step();
    check("hold_flush_c3", flush_done, 0);
    flush_req = 1'b0;
    step();

    // Reset mid-burst discards everything and clears sticky errors.
    host_rd_ready = 1'b0;
    drive(4'b1111, 32'hDDCCBBAA);
    step();
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", host_rd_valid, 0);
    check("mid_rst_err_status", error_status, 0);
    check("mid_rst_err_lane", error_lane, 0);
    rst_n = 1'b1;
    host_rd_ready = 1'b1;
    step(); step();
    check("mid_rst_no_leak", host_rd_valid, 0);

    drain(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
